// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-controlled programmable serial sequence detector with Mealy match output
module seq_det_ctrl #(
    parameter  int MAXLEN = 8,
    parameter  int CNTW   = 8,
    localparam int LENW   = $clog2(MAXLEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cfg_wr_i,
    input  logic [MAXLEN-1:0] cfg_pat_i,
    input  logic [LENW-1:0]   cfg_len_i,
    input  logic              cfg_ovl_i,
    output logic              cfg_err_o,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [CNTW-1:0]   tgt_cnt_i,
    input  logic              din_i,
    input  logic              din_vld_i,
    output logic              y_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNTW-1:0]   match_cnt_o,
    input  logic              cnt_clr_i
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e            state_q, state_d;
    logic [MAXLEN-1:0] pat_q, pat_d;
    logic [LENW-1:0]   len_q, len_d;
    logic              ovl_q, ovl_d;
    logic [MAXLEN-2:0] hist_q, hist_d;
    logic [LENW-1:0]   fill_q, fill_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [MAXLEN-1:0] win;
    logic [MAXLEN-1:0] mask;
    logic              cfg_ok;
    for (genvar i = 0; i < MAXLEN; i++) begin : g_mask
        assign mask[i] = LENW'(i) < len_q;
    end
    assign win         = {hist_q, din_i};
    assign cfg_ok      = (state_q == IDLE) && (cfg_len_i != '0) && (cfg_len_i <= LENW'(MAXLEN));
    assign busy_o      = state_q == RUN;
    assign done_o      = state_q == DONE;
    assign match_cnt_o = cnt_q;
    assign cfg_err_o   = err_q;
    assign y_o         = busy_o & din_vld_i & (fill_q >= len_q - LENW'(1)) & (((win ^ pat_q) & mask) == '0);
    // Next state: config latch, history shift, match counting, then run control (Stop over Start)
    always_comb begin
        state_d = state_q;
        pat_d   = cfg_wr_i && cfg_ok ? cfg_pat_i : pat_q;
        len_d   = cfg_wr_i && cfg_ok ? cfg_len_i : len_q;
        ovl_d   = cfg_wr_i && cfg_ok ? cfg_ovl_i : ovl_q;
        err_d   = cfg_wr_i && !cfg_ok;
        hist_d  = busy_o && din_vld_i ? (MAXLEN-1)'(win) : hist_q;
        fill_d  = !(busy_o && din_vld_i) ? fill_q :
                  (y_o && !ovl_q) ? '0 :
                  (fill_q == LENW'(MAXLEN)) ? fill_q : fill_q + LENW'(1);
        cnt_d   = cnt_clr_i ? '0 : (y_o && !(&cnt_q)) ? cnt_q + CNTW'(1) : cnt_q;
        if (y_o && tgt_cnt_i != '0 && cnt_d == tgt_cnt_i) state_d = DONE;
        if (stop_i) state_d = IDLE;
        else if (start_i) begin
            state_d = RUN;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
        end
    end
    // State and datapath registers with synchronous active-low reset to the default 101b pattern
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pat_q   <= MAXLEN'(5);
            len_q   <= LENW'(3);
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed and randomized checking of seq_det_ctrl against a queue-based model
module tb_seq_det_ctrl;
    localparam int MAXLEN = 8;
    localparam int CNTW   = 8;
    localparam int LENW   = $clog2(MAXLEN + 1);

    logic              clk = 1'b0;
    logic              rst_n, cfg_wr, cfg_ovl, start, stop, din, din_vld, cnt_clr;
    logic [MAXLEN-1:0] cfg_pat;
    logic [LENW-1:0]   cfg_len;
    logic [CNTW-1:0]   tgt_cnt;
    logic              cfg_err, y, busy, done;
    logic [CNTW-1:0]   match_cnt;

    int errors = 0;
    int checks = 0;

    // model state: 0 idle, 1 run, 2 done; history queue holds newest bit at index 0
    int                m_state, m_len, m_fill, m_cnt;
    logic [MAXLEN-1:0] m_pat;
    bit                m_ovl, m_err;
    bit                m_hist[$];

    seq_det_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_wr_i(cfg_wr), .cfg_pat_i(cfg_pat),
        .cfg_len_i(cfg_len), .cfg_ovl_i(cfg_ovl), .cfg_err_o(cfg_err),
        .start_i(start), .stop_i(stop), .tgt_cnt_i(tgt_cnt), .din_i(din),
        .din_vld_i(din_vld), .y_o(y), .busy_o(busy), .done_o(done),
        .match_cnt_o(match_cnt), .cnt_clr_i(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_y();
        if (m_state != 1 || din_vld !== 1'b1) return 1'b0;
        if (m_fill < m_len - 1) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            bit b;
            b = (k == 0) ? din : ((k - 1 < m_hist.size()) ? m_hist[k-1] : 1'b0);
            if (b != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_state = 0; m_pat = MAXLEN'(5); m_len = 3; m_ovl = 1'b1;
        m_hist.delete(); m_fill = 0; m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic m_step();
        bit y_now, ok;
        int old;
        y_now = m_y();
        old = m_state;
        if (!rst_n) begin
            m_reset();
            return;
        end
        ok = (old == 0) && (cfg_len >= 1) && (cfg_len <= MAXLEN);
        m_err = cfg_wr && !ok;
        if (old == 1 && din_vld) begin
            m_hist.push_front(din);
            if (m_hist.size() > MAXLEN) void'(m_hist.pop_back());
            m_fill = (y_now && !m_ovl) ? 0 : ((m_fill + 1 > MAXLEN) ? MAXLEN : m_fill + 1);
        end
        if (cfg_wr && ok) begin
            m_pat = cfg_pat; m_len = int'(cfg_len); m_ovl = cfg_ovl;
        end
        if (y_now) m_cnt = (m_cnt == 2**CNTW - 1) ? m_cnt : m_cnt + 1;
        if (cnt_clr) m_cnt = 0;
        if (y_now && tgt_cnt != 0 && m_cnt == int'(tgt_cnt)) m_state = 2;
        if (stop) m_state = 0;
        else if (start) begin
            m_state = 1; m_hist.delete(); m_fill = 0; m_cnt = 0;
        end
    endtask

    // Compare every output against the model on the falling edge, then advance the model
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            chk("y", y, m_y());
            chk("busy", busy, m_state == 1);
            chk("done", done, m_state == 2);
            chk("match_cnt", match_cnt, m_cnt);
            chk("cfg_err", cfg_err, m_err);
            m_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input string nm, input bit d, input bit v, input bit ey);
        din = d; din_vld = v;
        @(negedge clk);
        chk(nm, y, ey);
        tick();
        din_vld = 1'b0;
    endtask

    task automatic cfg(input logic [MAXLEN-1:0] p, input int l, input bit o);
        cfg_wr = 1'b1; cfg_pat = p; cfg_len = LENW'(l); cfg_ovl = o;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_wr = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
        start = 1'b0; stop = 1'b0; tgt_cnt = '0; din = 1'b0; din_vld = 1'b0; cnt_clr = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_cnt", match_cnt, 0);
        tick();
        rst_n = 1'b1;
        // default 101b overlapping
        pulse_start();
        bit_in("t1_b1", 1, 1, 0); bit_in("t1_b2", 0, 1, 0); bit_in("t1_b3", 1, 1, 1);
        bit_in("t1_b4", 0, 1, 0); bit_in("t1_b5", 1, 1, 1);
        @(negedge clk);
        chk("t1_cnt", match_cnt, 2);
        chk("t1_busy", busy, 1);
        tick();
        // non-overlapping
        pulse_stop();
        cfg(MAXLEN'(5), 3, 1'b0);
        pulse_start();
        bit_in("t2_b1", 1, 1, 0); bit_in("t2_b2", 0, 1, 0); bit_in("t2_b3", 1, 1, 1);
        bit_in("t2_b4", 0, 1, 0); bit_in("t2_b5", 1, 1, 0);
        @(negedge clk);
        chk("t2_cnt", match_cnt, 1);
        tick();
        // rejected config writes
        cfg(MAXLEN'(15), 4, 1'b1);
        @(negedge clk);
        chk("t3_err_run", cfg_err, 1);
        tick();
        @(negedge clk);
        chk("t3_err_clear", cfg_err, 0);
        tick();
        pulse_stop();
        cfg(MAXLEN'(15), 0, 1'b1);
        @(negedge clk);
        chk("t3_err_len0", cfg_err, 1);
        tick();
        pulse_start();
        bit_in("t3_b1", 1, 1, 0); bit_in("t3_b2", 0, 1, 0); bit_in("t3_b3", 1, 1, 1);
        bit_in("t3_b4", 0, 1, 0); bit_in("t3_b5", 1, 1, 0);
        // target count reaches DONE
        pulse_stop();
        cfg(MAXLEN'(3), 2, 1'b1);
        tgt_cnt = CNTW'(2);
        pulse_start();
        bit_in("t4_b1", 1, 1, 0); bit_in("t4_b2", 1, 1, 1); bit_in("t4_b3", 1, 1, 1);
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_cnt", match_cnt, 2);
        tick();
        bit_in("t4_y_done", 1, 1, 0);
        tgt_cnt = '0;
        // valid gaps and clear on the match cycle
        pulse_stop();
        cfg(MAXLEN'(5), 3, 1'b1);
        pulse_start();
        bit_in("t5_b1", 1, 1, 0); bit_in("t5_g1", 1, 0, 0);
        bit_in("t5_b2", 0, 1, 0); bit_in("t5_g2", 1, 0, 0);
        cnt_clr = 1'b1;
        bit_in("t5_b3", 1, 1, 1);
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("t5_cnt", match_cnt, 0);
        tick();
        // reset mid-run swallowing a match, then Start+Stop together
        bit_in("t6_b1", 0, 1, 0); bit_in("t6_b2", 1, 1, 1);
        bit_in("t6_b3", 0, 1, 0);
        din = 1'b1; din_vld = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; din_vld = 1'b0;
        @(negedge clk);
        chk("t6_cnt", match_cnt, 0);
        chk("t6_busy", busy, 0);
        tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("t6_busy2", busy, 0);
        chk("t6_done2", done, 0);
        tick();
        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            start   = ($urandom_range(0, 29) == 0);
            stop    = ($urandom_range(0, 59) == 0);
            cfg_wr  = ($urandom_range(0, 19) == 0);
            cnt_clr = ($urandom_range(0, 79) == 0);
            cfg_pat = MAXLEN'($urandom);
            cfg_len = ($urandom_range(0, 7) == 0) ? LENW'($urandom) : LENW'($urandom_range(1, 4));
            cfg_ovl = $urandom_range(0, 1) != 0;
            tgt_cnt = ($urandom_range(0, 1) != 0) ? '0 : CNTW'($urandom_range(1, 6));
            din     = $urandom_range(0, 1) != 0;
            din_vld = $urandom_range(0, 3) != 0;
            tick();
        end
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; cfg_wr = 1'b0; cnt_clr = 1'b0; din_vld = 1'b0;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
